// File: rtl/nn_pkg.sv
// Shared constants and types for the neural-network datapath blocks.
package nn_pkg;

    localparam int unsigned FPL_DEFAULT  = 16;
    localparam int unsigned FPP_DEFAULT  = 10;
    localparam int unsigned MULT_LATENCY = 5;
    localparam int unsigned TAG_ID_W     = 4;

    typedef logic signed [FPL_DEFAULT-1:0] fixed_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a registered pointer.
module round_robin_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_advance,
    output logic [N-1:0]  o_grant_c,
    output logic [IW-1:0] o_grant_idx_c
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_grant_c     = '0;
        o_grant_idx_c = '0;
        w_idx         = '0;
        w_found       = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = IW'((32'(r_ptr) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                o_grant_c[w_idx] = 1'b1;
                o_grant_idx_c    = w_idx;
                w_found          = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority next time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_grant_idx_c == IW'(N-1)) ? '0 : o_grant_idx_c + IW'(1);
        end
    end

endmodule

// File: rtl/signed_fixed_point_multiplier.sv
// Pipelined signed fixed-point multiplier with saturation; fixed latency, no stall, no reset.
module signed_fixed_point_multiplier
    import nn_pkg::*;
#(
    parameter int unsigned FPL = FPL_DEFAULT,
    parameter int unsigned FPP = FPP_DEFAULT
) (
    input  logic                  i_clk,
    input  logic signed [FPL-1:0] i_a,
    input  logic signed [FPL-1:0] i_b,
    output logic signed [FPL-1:0] o_product
);

    localparam int unsigned PW = 2 * FPL;
    localparam logic signed [PW-1:0] MAX_V = {{(PW-FPL+1){1'b0}}, {(FPL-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = {{(PW-FPL+1){1'b1}}, {(FPL-1){1'b0}}};

    logic signed [FPL-1:0] r_a;
    logic signed [FPL-1:0] r_b;
    logic signed [PW-1:0]  r_prod;
    logic signed [PW-1:0]  w_shift;
    logic signed [FPL-1:0] w_sat;
    logic signed [FPL-1:0] r_dly [MULT_LATENCY-2];

    // Arithmetic shift floors toward -inf before clamping to the representable range.
    always_comb begin
        w_shift = r_prod >>> FPP;
        if (w_shift > MAX_V) begin
            w_sat = FPL'(MAX_V);
        end else if (w_shift < MIN_V) begin
            w_sat = FPL'(MIN_V);
        end else begin
            w_sat = FPL'(w_shift);
        end
    end

    always_ff @(posedge i_clk) begin
        r_a      <= i_a;
        r_b      <= i_b;
        r_prod   <= PW'(r_a) * PW'(r_b);
        r_dly[0] <= w_sat;
        for (int unsigned i = 1; i < MULT_LATENCY - 2; i++) begin
            r_dly[i] <= r_dly[i-1];
        end
    end

    assign o_product = r_dly[MULT_LATENCY-3];

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one pipelined fixed-point multiplier among N requesters; tags route each product
// back to its owner via a one-hot result valid.
module multiplier_arbiter
    import nn_pkg::*;
#(
    parameter  int unsigned NUM_REQUESTERS       = 4,
    parameter  int unsigned FIXED_POINT_LENGTH   = FPL_DEFAULT,
    parameter  int unsigned FIXED_POINT_POSITION = FPP_DEFAULT,
    localparam int unsigned CW                   = $clog2(MULT_LATENCY + 1)
) (
    input  logic                                               clk_in,
    input  logic                                               rst_n_in,
    input  logic [NUM_REQUESTERS-1:0]                          req_valid_in,
    input  logic [NUM_REQUESTERS-1:0][FIXED_POINT_LENGTH-1:0]  req_multiplicand_in,
    input  logic [NUM_REQUESTERS-1:0][FIXED_POINT_LENGTH-1:0]  req_multiplier_in,
    output logic [NUM_REQUESTERS-1:0]                          req_ready_out,
    output logic [NUM_REQUESTERS-1:0]                          result_valid_out,
    output logic [FIXED_POINT_LENGTH-1:0]                      product_out,
    output logic [CW-1:0]                                      inflight_count_out
);

    localparam int unsigned N   = NUM_REQUESTERS;
    localparam int unsigned FPL = FIXED_POINT_LENGTH;
    localparam int unsigned IW  = $clog2(N);

    logic [N-1:0]          w_grant;
    logic [IW-1:0]         w_grant_idx;
    logic                  w_handshake;
    logic signed [FPL-1:0] w_a;
    logic signed [FPL-1:0] w_b;
    logic signed [FPL-1:0] w_product;
    tag_t                  w_new_tag;
    tag_t                  r_tag [MULT_LATENCY-1];
    logic [N-1:0]          r_result_valid;
    logic [CW-1:0]         r_count;
    logic                  w_pop;

    round_robin_arbiter #(.N(N)) u_rr (
        .i_clk         (clk_in),
        .i_rst_n       (rst_n_in),
        .i_req         (req_valid_in),
        .i_advance     (w_handshake),
        .o_grant_c     (w_grant),
        .o_grant_idx_c (w_grant_idx)
    );

    assign w_handshake = |w_grant;
    assign w_pop       = |r_result_valid;

    // Idle cycles feed zeros so the datapath never toggles on stale operands.
    always_comb begin
        w_a             = '0;
        w_b             = '0;
        w_new_tag.valid = w_handshake;
        w_new_tag.id    = TAG_ID_W'(w_grant_idx);
        if (w_handshake) begin
            w_a = req_multiplicand_in[w_grant_idx];
            w_b = req_multiplier_in[w_grant_idx];
        end
    end

    signed_fixed_point_multiplier #(
        .FPL (FPL),
        .FPP (FIXED_POINT_POSITION)
    ) u_mult (
        .i_clk     (clk_in),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_product (w_product)
    );

    // Final tag stage is held as a decoded one-hot so it lines up with the product register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < MULT_LATENCY - 1; i++) begin
                r_tag[i] <= '0;
            end
            r_result_valid <= '0;
        end else begin
            r_tag[0] <= w_new_tag;
            for (int unsigned i = 1; i < MULT_LATENCY - 1; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_result_valid <= r_tag[MULT_LATENCY-2].valid ?
                              (N'(1) << r_tag[MULT_LATENCY-2].id) : '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count <= '0;
        end else begin
            case ({w_handshake, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign req_ready_out      = w_grant;
    assign result_valid_out   = r_result_valid;
    assign product_out        = w_product;
    assign inflight_count_out = r_count;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter: hand-computed grants and products tracked through
// a small expected-result pipeline.
module tb_multiplier_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned ML = 5;
    localparam int unsigned CW = $clog2(ML + 1);

    logic                clk_in = 1'b0;
    logic                rst_n_in;
    logic [N-1:0]        req_valid_in;
    logic [N-1:0][W-1:0] a_q;
    logic [N-1:0][W-1:0] b_q;
    logic [N-1:0]        req_ready_out;
    logic [N-1:0]        result_valid_out;
    logic [W-1:0]        product_out;
    logic [CW-1:0]       inflight_count_out;

    int n_vec = 0;
    int n_err = 0;

    logic         m_v  [ML];
    logic [N-1:0] m_oh [ML];
    logic [W-1:0] m_p  [ML];

    multiplier_arbiter dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .req_valid_in        (req_valid_in),
        .req_multiplicand_in (a_q),
        .req_multiplier_in   (b_q),
        .req_ready_out       (req_ready_out),
        .result_valid_out    (result_valid_out),
        .product_out         (product_out),
        .inflight_count_out  (inflight_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < ML; i++) begin
            m_v[i]  = 1'b0;
            m_oh[i] = '0;
            m_p[i]  = '0;
        end
    endtask

    task automatic check_outputs();
        int cnt;
        cnt = 0;
        for (int i = 0; i < ML; i++) cnt += m_v[i] ? 1 : 0;
        check_val("result_valid", 32'(result_valid_out), m_v[ML-1] ? 32'(m_oh[ML-1]) : 32'd0);
        if (m_v[ML-1]) check_val("product", 32'(product_out), 32'(m_p[ML-1]));
        check_val("inflight", 32'(inflight_count_out), 32'(cnt));
    endtask

    // Called just after a rising edge: drive valids, check grant, advance one cycle.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] exp_rdy,
                         input logic [W-1:0] exp_prod);
        req_valid_in = v;
        #1;
        check_val("ready", 32'(req_ready_out), 32'(exp_rdy));
        @(posedge clk_in);
        #1;
        for (int i = ML - 1; i > 0; i--) begin
            m_v[i]  = m_v[i-1];
            m_oh[i] = m_oh[i-1];
            m_p[i]  = m_p[i-1];
        end
        m_v[0]  = (exp_rdy != '0);
        m_oh[0] = exp_rdy;
        m_p[0]  = exp_prod;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n_in     = 1'b0;
        req_valid_in = '0;
        clear_model();
        #1;
        check_val("rst_ready", 32'(req_ready_out), 32'd0);
        check_val("rst_result_valid", 32'(result_valid_out), 32'd0);
        check_val("rst_inflight", 32'(inflight_count_out), 32'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
    endtask

    initial begin
        rst_n_in     = 1'b0;
        req_valid_in = '0;
        a_q          = '0;
        b_q          = '0;
        do_reset();

        // Single product: 1.5 * 2.0 = 3.0
        a_q[0] = 16'h0600; b_q[0] = 16'h0800;
        cycle(4'b0001, 4'b0001, 16'h0C00);
        idle(6);

        // Sign and saturation, back-to-back from one lone requester
        a_q[0] = 16'hFA00; b_q[0] = 16'h0800;
        cycle(4'b0001, 4'b0001, 16'hF400);
        a_q[0] = 16'h7FFF; b_q[0] = 16'h7FFF;
        cycle(4'b0001, 4'b0001, 16'h7FFF);
        a_q[0] = 16'h8000; b_q[0] = 16'h7FFF;
        cycle(4'b0001, 4'b0001, 16'h8000);
        idle(6);

        // Fairness and full pipe: operands 1.0..4.0 times 2.0
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_q[i] = W'(16'h0400 * (i + 1));
            b_q[i] = 16'h0800;
        end
        for (int r = 0; r < 2; r++) begin
            cycle(4'b1111, 4'b0001, 16'h0800);
            cycle(4'b1111, 4'b0010, 16'h1000);
            cycle(4'b1111, 4'b0100, 16'h1800);
            cycle(4'b1111, 4'b1000, 16'h2000);
        end
        idle(6);

        // Sparse: move pointer to 2, then 1 and 3 compete
        cycle(4'b0010, 4'b0010, 16'h1000);
        cycle(4'b1010, 4'b1000, 16'h2000);
        cycle(4'b1010, 4'b0010, 16'h1000);
        idle(6);

        // Reset with three products in flight
        cycle(4'b1111, 4'b0100, 16'h1800);
        cycle(4'b1111, 4'b1000, 16'h2000);
        cycle(4'b1111, 4'b0001, 16'h0800);
        check_val("inflight_pre_reset", 32'(inflight_count_out), 32'd3);
        do_reset();
        cycle(4'b1010, 4'b0010, 16'h1000);
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
